// File: rtl/debug_pkg.sv
// Shared types for the debug/telemetry UART.
// TX and RX state encodings plus UART frame geometry.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit.
// Every bit lasts TICKS_PER_BIT clocks; tx_done marks the last stop cycle.
module uart_tx
    import debug_pkg::*;
#(
    parameter int TICKS_PER_BIT = 217
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = $clog2(TICKS_PER_BIT);
    localparam logic [CW-1:0] C_LAST = CW'(TICKS_PER_BIT - 1);
    localparam logic [3:0] B_LAST = 4'(FRAME_BITS - 1);

    // Holds the bits still to go out after the one on the line.
    logic [FRAME_BITS-2:0] r_frame;
    logic [3:0]            r_bit;
    logic [CW-1:0]         r_cnt;
    logic                  r_busy;
    logic                  r_tx;
    logic                  w_bit_end;

    assign w_bit_end = r_busy && (r_cnt == C_LAST);
    assign tx_done   = w_bit_end && (r_bit == B_LAST);
    assign tx_busy   = r_busy;
    assign tx_out    = r_tx;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_frame <= '1;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
        end else if (!r_busy) begin
            if (tx_start) begin
                r_frame <= {1'b1, tx_byte};
                r_bit   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_tx    <= 1'b0;
            end
        end else if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == B_LAST) begin
                r_busy <= 1'b0;
                r_tx   <= 1'b1;
            end else begin
                r_bit   <= r_bit + 4'd1;
                r_tx    <= r_frame[0];
                r_frame <= {1'b1, r_frame[FRAME_BITS-2:1]};
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_debugger.sv
// Periodic status-word transmitter (MSB byte first) plus
// single-byte command receiver, both 8N1 at the same bit rate.
module uart_debugger
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int DIVIDER_TICKS      = 25000000,
    parameter int UART_TICKS_PER_BIT = 217
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  debug_uart_rx_in,
    output logic [7:0]            debug_command,
    output logic                  debug_command_pulse,
    output logic                  debug_command_busy,
    output logic                  tx_out
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int DW = $clog2(DIVIDER_TICKS);
    localparam int IW = $clog2(NB + 1);
    localparam int RW = $clog2(UART_TICKS_PER_BIT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);
    localparam logic [RW-1:0] RX_HALF  = RW'(UART_TICKS_PER_BIT / 2);
    localparam logic [RW-1:0] RX_FULL  = RW'(UART_TICKS_PER_BIT);
    localparam logic [RW-1:0] RX_ONE   = RW'(1);

    logic [DW-1:0] r_div_cnt;
    logic          w_tick;

    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk_in) begin
        if (reset)       r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    tx_state_t             r_tx_state, w_tx_next;
    logic [DATA_WIDTH-1:0] r_bits;
    logic [IW-1:0]         r_idx;
    logic                  w_load, w_start, w_shift;
    logic                  w_tx_busy, w_tx_done;

    always_comb begin
        w_tx_next = r_tx_state;
        w_load    = 1'b0;
        w_start   = 1'b0;
        w_shift   = 1'b0;
        unique case (r_tx_state)
            IDLE: if (w_tick) begin
                w_load    = 1'b1;
                w_tx_next = LOAD;
            end
            LOAD: w_tx_next = SEND;
            SEND: if (!w_tx_busy) begin
                w_start   = 1'b1;
                w_tx_next = WAIT_DONE;
            end
            WAIT_DONE: if (w_tx_done) begin
                w_shift   = 1'b1;
                w_tx_next = (r_idx == IDX_LAST) ? IDLE : SEND;
            end
            default: w_tx_next = IDLE;
        endcase
    end

    // The snapshot shifts left so the next byte is always on top.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_tx_state <= IDLE;
            r_bits     <= '0;
            r_idx      <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_load) begin
                r_bits <= data_in;
                r_idx  <= '0;
            end else if (w_shift) begin
                r_bits <= r_bits << 8;
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    uart_tx #(
        .TICKS_PER_BIT(UART_TICKS_PER_BIT)
    ) u_tx (
        .clk_in  (clk_in),
        .reset   (reset),
        .tx_start(w_start),
        .tx_byte (r_bits[DATA_WIDTH-1 -: 8]),
        .tx_out  (tx_out),
        .tx_busy (w_tx_busy),
        .tx_done (w_tx_done)
    );

    rx_state_t     r_rx_state, w_rx_next;
    logic          r_sync1, r_sync2, r_rx_prev;
    logic [RW-1:0] r_rx_cnt, w_rx_cnt_next;
    logic [2:0]    r_rx_bit, w_rx_bit_next;
    logic [7:0]    r_rx_shift, w_rx_shift_next;
    logic [7:0]    r_cmd, w_cmd_next;
    logic          r_pulse, w_pulse_next;
    logic          w_rx;

    assign w_rx                = r_sync2;
    assign debug_command       = r_cmd;
    assign debug_command_pulse = r_pulse;
    assign debug_command_busy  = (r_rx_state == RX_START) ||
                                 (r_rx_state == RX_DATA)  ||
                                 (r_rx_state == RX_STOP);

    // r_rx_prev resets low, so a start needs the line seen high first.
    always_comb begin
        w_rx_next       = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt + 1'b1;
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_cmd_next      = r_cmd;
        w_pulse_next    = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_next = RX_ONE;
                if (r_rx_prev && !w_rx) w_rx_next = RX_START;
            end
            RX_START: if (r_rx_cnt == RX_HALF) begin
                w_rx_cnt_next = RX_ONE;
                w_rx_bit_next = '0;
                w_rx_next     = w_rx ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (r_rx_cnt == RX_FULL) begin
                w_rx_cnt_next   = RX_ONE;
                w_rx_shift_next = {w_rx, r_rx_shift[7:1]};
                if (r_rx_bit == 3'd7) w_rx_next = RX_STOP;
                else w_rx_bit_next = r_rx_bit + 3'd1;
            end
            RX_STOP: if (r_rx_cnt == RX_FULL) begin
                if (w_rx) begin
                    w_cmd_next   = r_rx_shift;
                    w_pulse_next = 1'b1;
                    w_rx_next    = RX_IDLE;
                end else begin
                    w_rx_next = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: if (w_rx) w_rx_next = RX_IDLE;
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_rx_prev  <= 1'b0;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_cmd      <= '0;
            r_pulse    <= 1'b0;
        end else begin
            r_sync1    <= debug_uart_rx_in;
            r_sync2    <= r_sync1;
            r_rx_prev  <= w_rx;
            r_rx_state <= w_rx_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
            r_cmd      <= w_cmd_next;
            r_pulse    <= w_pulse_next;
        end
    end

endmodule

// File: tb/tb_uart_debugger.sv
// Directed bench: TX framing/timing, tick dropping, RX commands,
// framing errors and mid-frame reset on 16-bit, T=4 instances.
module tb_uart_debugger;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst, rst_f, rx, rx_f;
    logic [15:0] dat, dat_f;
    logic [7:0]  cmd, cmd_f;
    logic        pls, pls_f, bsy, bsy_f, tx_s, tx_f;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_debugger #(
        .DATA_WIDTH(16), .DIVIDER_TICKS(200), .UART_TICKS_PER_BIT(T)
    ) u_dut (
        .clk_in(clk), .reset(rst), .data_in(dat),
        .debug_uart_rx_in(rx), .debug_command(cmd),
        .debug_command_pulse(pls), .debug_command_busy(bsy),
        .tx_out(tx_s)
    );

    uart_debugger #(
        .DATA_WIDTH(16), .DIVIDER_TICKS(20), .UART_TICKS_PER_BIT(T)
    ) u_dut_fast (
        .clk_in(clk), .reset(rst_f), .data_in(dat_f),
        .debug_uart_rx_in(rx_f), .debug_command(cmd_f),
        .debug_command_pulse(pls_f), .debug_command_busy(bsy_f),
        .tx_out(tx_f)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for a start bit, then samples all 40 cycles of the frame.
    task automatic get_byte(input bit sel, output logic [9:0] frm,
                            output int bad, output int st);
        int   n;
        logic v;
        frm = '0;
        bad = 0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
            v = sel ? tx_f : tx_s;
        end while (v !== 1'b0 && n < 400);
        st = cyc;
        chk("tx start seen", {31'd0, v}, 32'd0);
        if (v === 1'b0) begin
            for (int i = 0; i < 10 * T; i++) begin
                if (i > 0) @(negedge clk);
                v = sel ? tx_f : tx_s;
                if (i % T == 0) frm[i / T] = v;
                else if (v !== frm[i / T]) bad++;
            end
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stopb,
                            output int pulses, output int busy_n,
                            output logic [7:0] cmd_p);
        logic [9:0] f;
        f      = {stopb, b, 1'b0};
        pulses = 0;
        busy_n = 0;
        cmd_p  = 8'h00;
        for (int i = 0; i < 10 * T + 12; i++) begin
            @(negedge clk);
            rx = (i < 10 * T) ? f[i / T] : 1'b1;
            if (pls === 1'b1) begin
                pulses++;
                cmd_p = cmd;
            end
            if (bsy === 1'b1) busy_n++;
        end
    endtask

    logic [9:0] frm;
    logic [7:0] cp;
    int         bad, st, st1, t0, lat, pc, bc, n;
    int         sf[6];

    initial begin
        rst   = 1'b1;
        rst_f = 1'b1;
        rx    = 1'b1;
        rx_f  = 1'b1;
        dat   = 16'hA55A;
        dat_f = 16'hBEEF;
        repeat (3) @(negedge clk);
        chk("reset tx_out", {31'd0, tx_s}, 32'd1);
        chk("reset cmd", {24'd0, cmd}, 32'd0);
        chk("reset pulse", {31'd0, pls}, 32'd0);
        chk("reset busy", {31'd0, bsy}, 32'd0);

        rst = 1'b0;
        t0  = cyc;
        get_byte(1'b0, frm, bad, st);
        st1 = st;
        lat = st - t0 - 199;
        chk("A5 frame", {22'd0, frm}, {22'd0, 10'b1101001010});
        chk("A5 bit width", bad, 0);
        chk("first start <=3 after tick", {31'd0, (lat >= 0 && lat <= 3)}, 1);
        dat = 16'h1234;
        get_byte(1'b0, frm, bad, st);
        chk("5A frame", {22'd0, frm}, {22'd0, 1'b1, 8'h5A, 1'b0});
        chk("5A bit width", bad, 0);
        chk("interbyte gap <=3",
            {31'd0, (st - st1 - 10 * T) <= 3}, 1);
        get_byte(1'b0, frm, bad, st);
        chk("tick period", st - st1, 200);
        chk("12 frame", {22'd0, frm}, {22'd0, 1'b1, 8'h12, 1'b0});
        get_byte(1'b0, frm, bad, st);
        chk("34 frame", {22'd0, frm}, {22'd0, 1'b1, 8'h34, 1'b0});
        chk("34 bit width", bad, 0);

        rst_f = 1'b0;
        for (int m = 0; m < 6; m++) begin
            get_byte(1'b1, frm, bad, sf[m]);
            chk("fast frame", {22'd0, frm},
                {22'd0, 1'b1, (m % 2 == 0) ? 8'hBE : 8'hEF, 1'b0});
            chk("fast bit width", bad, 0);
        end
        chk("fast msg spacing 1", sf[2] - sf[0], 100);
        chk("fast msg spacing 2", sf[4] - sf[2], 100);
        chk("fast rx idle pulse", {31'd0, pls_f}, 32'd0);
        chk("fast rx idle busy", {31'd0, bsy_f}, 32'd0);
        chk("fast rx idle cmd", {24'd0, cmd_f}, 32'd0);

        rx_frame(8'h3C, 1'b1, pc, bc, cp);
        chk("3C pulse count", pc, 1);
        chk("3C cmd at pulse", {24'd0, cp}, 32'h3C);
        chk("3C busy cycles", bc, 38);
        chk("3C cmd held", {24'd0, cmd}, 32'h3C);

        rx_frame(8'h55, 1'b0, pc, bc, cp);
        chk("55 framing pulse", pc, 0);
        chk("55 framing cmd", {24'd0, cmd}, 32'h3C);

        rx_frame(8'hC3, 1'b1, pc, bc, cp);
        chk("C3 pulse count", pc, 1);
        chk("C3 cmd", {24'd0, cmd}, 32'hC3);

        pc = 0;
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (pls === 1'b1) pc++;
        end
        chk("glitch pulse", pc, 0);
        chk("glitch busy", {31'd0, bsy}, 32'd0);

        pc = 0;
        rx = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (pls === 1'b1) pc++;
        end
        chk("const0 pulse", pc, 0);
        chk("const0 busy", {31'd0, bsy}, 32'd0);
        chk("const0 cmd", {24'd0, cmd}, 32'hC3);
        rx = 1'b1;
        repeat (4) @(negedge clk);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_s !== 1'b0 && n < 500);
        chk("tx low before reset", {31'd0, tx_s}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midframe reset tx_out", {31'd0, tx_s}, 32'd1);
        chk("midframe reset cmd", {24'd0, cmd}, 32'd0);
        chk("midframe reset pulse", {31'd0, pls}, 32'd0);
        chk("midframe reset busy", {31'd0, bsy}, 32'd0);
        rst = 1'b0;
        t0  = cyc;
        get_byte(1'b0, frm, bad, st);
        lat = st - t0 - 199;
        chk("post-reset latency", {31'd0, (lat >= 0 && lat <= 3)}, 1);
        chk("post-reset 12 frame", {22'd0, frm},
            {22'd0, 1'b1, 8'h12, 1'b0});
        get_byte(1'b0, frm, bad, st);
        chk("post-reset 34 frame", {22'd0, frm},
            {22'd0, 1'b1, 8'h34, 1'b0});
        chk("post-reset bit width", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_debugger.md
Name: uart_debugger

Overview:
- Debug/telemetry UART block.
- Every DIVIDER_TICKS clocks it snapshots a wide status word (data_in) and transmits it on tx_out as consecutive 8N1 UART bytes, most-significant byte first.
- It also receives single-byte commands on debug_uart_rx_in and presents each valid byte with a one-cycle strobe.
- Used inside the display controller for host debugging; testbenches also use it as a plain serial data source.

Parameters:
- DATA_WIDTH, 32, width of data_in in bits; must be a nonzero multiple of 8. Byte count N = DATA_WIDTH/8.
- DIVIDER_TICKS, 25000000, clocks between snapshot ticks (1 msg/s at 25 MHz); must be ≥ 2.
- UART_TICKS_PER_BIT, 217, clocks per UART bit (T); must be ≥ 4. Applies to both TX and RX.

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  status word; sampled only on an accepted tick.
- debug_uart_rx_in  in  1  asynchronous UART RX line; idle high.
- debug_command  out  8  last valid received byte.
- debug_command_pulse  out  1  one-cycle strobe: debug_command was just updated.
- debug_command_busy  out  1  high while an RX frame is in progress.
- tx_out  out  1  UART TX line; idle high.

Behaviour:
- Reset (synchronous, active-high):
  - tx_out=1, debug_command=0, debug_command_pulse=0, debug_command_busy=0.
  - Divider counter=0, TX FSM=IDLE, RX FSM=RX_IDLE, snapshot register=0.
  - Asserting reset mid-frame aborts immediately: tx_out returns high on the next edge.
- Divider:
  - Counts 0..DIVIDER_TICKS-1 and wraps.
  - The tick is the cycle in which count==DIVIDER_TICKS-1.
  - The first tick occurs DIVIDER_TICKS cycles after reset deasserts.
- TX FSM, states IDLE → LOAD → SEND → WAIT_DONE → (SEND | IDLE):
  - IDLE: on a tick, register data_in into debug_bits, set byte index=0, go to LOAD.
  - A tick arriving while not IDLE is dropped; messages never queue or overlap.
  - LOAD→SEND is one cycle. SEND pulses tx_start to the byte transmitter for one cycle with byte debug_bits[DATA_WIDTH-1-8*idx -: 8].
  - WAIT_DONE waits for tx_done. Then idx++; if idx<N go to SEND, else go to IDLE.
- Byte transmitter (8N1):
  - Frame order: start bit (0), data bits LSB first, stop bit (1). Each bit is exactly T cycles.
  - tx_out drives the start bit on the edge following tx_start.
  - tx_busy is high from tx_start until the end of the stop bit.
  - tx_done pulses one cycle at the end of the stop bit.
  - Gap between consecutive frames of one message: at most 3 cycles of idle-high.
- Message latency: first start bit begins ≤ 3 cycles after the tick. Total message ≈ N·(10T+3) cycles.
- RX:
  - 2-flop synchronizer on debug_uart_rx_in, adding 2 cycles latency.
  - RX_IDLE: arms only after the synchronized line has been seen high.
  - Start detection: falling edge. Sample at T/2 (integer division); if high, treat as a glitch and return to RX_IDLE.
  - Data: 8 samples every T, LSB first. Then the stop bit is sampled at T later.
  - Stop bit high: debug_command <= byte and debug_command_pulse=1 for exactly one cycle, in the same cycle busy falls.
  - Stop bit low (framing error or break): no pulse, debug_command unchanged. Return to RX_IDLE and re-arm only after the line returns high.
  - A line held at constant 0 therefore yields at most one aborted frame and never a pulse.
  - debug_command_busy is high from the cycle after start detection through the stop-bit sample cycle.
- RX and TX are fully independent; a simultaneous tick and RX completion are both honoured.

Decomposition:
- Shared package debug_pkg:
  - TX state enum (IDLE, LOAD, SEND, WAIT_DONE).
  - RX state enum (RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH).
  - Localparam for UART frame bits (10).
- One natural sub-module: uart_tx (byte transmitter), with ports clk_in, reset, tx_start, tx_byte[7:0], tx_out, tx_busy, tx_done.
- RX logic stays inline.

Test Plan:
- DATA_WIDTH=16, T=4, DIVIDER_TICKS=200, data_in=16'hA55A. Decode tx_out → bytes 0xA5 then 0x5A.
  - Bit sequence of byte 1: 0,1,0,1,0,0,1,0,1,1.
  - Each bit exactly 4 cycles.
  - First start bit ≤ 3 cycles after cycle 199 post-reset.
- Same config, data_in changes to 16'h1234 mid-message. The current message still sends A5 5A; the next tick sends 12 34.
- DIVIDER_TICKS=20 (shorter than one message). Verify ticks during transmission are dropped and messages never interleave; every message is complete.
- RX: drive a valid 0x3C frame at T=4. Required: debug_command=8'h3C, pulse high exactly 1 cycle, busy high for ~9.5T cycles then low.
- RX framing error:
  - Frame 0x55 with stop bit 0 → no pulse, debug_command stays at previous value.
  - After the line returns high, a valid 0xC3 frame → pulse, debug_command=8'hC3.
  - Constant 0 on RX → no pulse ever.
- Assert reset mid-byte. tx_out=1 on the next edge; all outputs at reset values; the next message starts cleanly after DIVIDER_TICKS.
